alg_issue_ctrl: RTL and testbench

ALG_ISSUE_CTRL -- requirements
Module: alg_issue_ctrl

---
 rtl/alg_issue_ctrl_pkg.sv | 37 +++
 rtl/alg_issue_ctrl_if.sv | 29 ++
 rtl/alg_unit.sv | 38 +++
 rtl/alg_issue_ctrl.sv | 133 +++++++++++++
 tb/tb_alg_issue_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/alg_issue_ctrl_pkg.sv
// Shared types for the LC-3b extended-ALU issue path.
//   lc3b_types          : datapath word/register types, extended-op codes
//                         and the issue-controller FSM state enum.
//   alg_issue_ctrl_pkg  : controller-local constants and helpers.
// No ports (package file).

package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_reg;
    typedef logic [2:0]  op_x_bits;

    localparam op_x_bits op_nop = 3'd0;
    localparam op_x_bits op_mul = 3'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        WB_HI = 2'd2,
        WB_LO = 2'd3
    } alg_state_e;

endpackage

package alg_issue_ctrl_pkg;

    import lc3b_types::*;

    localparam int        WD_W   = 4;
    localparam logic [3:0] WD_MAX = 4'hF;

    // Register pair partner for the low half of a product; R7 wraps to R0.
    function automatic lc3b_reg next_reg(input lc3b_reg r);
        return r + 3'd1;
    endfunction

endpackage

// File: rtl/alg_issue_ctrl_if.sv
// Bus between the issue controller and the multi-cycle functional unit.
//   fu_op, fu_opA, fu_opB : controller -> unit, request and operands
//   fu_done, fu_hi, fu_lo : unit -> controller, completion and product
//
// Handshake: fu_op == op_mul acts as "valid" and is held, together with
// stable operands, every cycle until the unit raises fu_done for one cycle
// ("ready"); fu_hi/fu_lo are only meaningful in that fu_done cycle.
// fu_op returns to op_nop the cycle after completion.

interface alg_issue_ctrl_if;
    import lc3b_types::*;

    op_x_bits fu_op;
    lc3b_word fu_opA;
    lc3b_word fu_opB;
    logic     fu_done;
    lc3b_word fu_hi;
    lc3b_word fu_lo;

    modport master (
        output fu_op, fu_opA, fu_opB,
        input  fu_done, fu_hi, fu_lo
    );

    modport slave (
        input  fu_op, fu_opA, fu_opB,
        output fu_done, fu_hi, fu_lo
    );
endinterface

// File: rtl/alg_unit.sv
// Multi-cycle multiplier used as the functional unit behind alg_issue_ctrl.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   lat         : extra cycles before fu_done (0 = done in first request cycle)
//   never_done  : when 1 the unit never completes (exercises the watchdog)
//   fu          : slave side of alg_issue_ctrl_if

module alg_unit
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  lat,
    input  logic        never_done,
    alg_issue_ctrl_if.slave fu
);

    logic [3:0]  cnt_q;
    logic [31:0] prod;
    logic        req;

    assign req  = (fu.fu_op == op_mul);
    assign prod = {16'b0, fu.fu_opA} * {16'b0, fu.fu_opB};

    assign fu.fu_done = req && !never_done && (cnt_q == lat);
    assign fu.fu_hi   = prod[31:16];
    assign fu.fu_lo   = prod[15:0];

    // Counts request cycles; restarts whenever the request is withdrawn.
    always_ff @(posedge clk) begin
        if (reset || !req) begin
            cnt_q <= 4'd0;
        end else if (!fu.fu_done && cnt_q != 4'hF) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

endmodule

// File: rtl/alg_issue_ctrl.sv
// Issue controller for the multi-cycle multiply. Accepts op_mul from EX,
// stalls the front of the pipe while the functional unit works, then writes
// the 32-bit product back as two register writes: hi to dest, lo to dest+1.
// A 4-bit watchdog aborts an operation the unit never finishes.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   ex_valid, ex_op, ex_opA/B,
//   ex_dest                       : instruction presented by EX
//   stall                         : freeze fetch/decode/EX
//   fu                            : master side of alg_issue_ctrl_if
//   wb_we, wb_dest, wb_data       : register-file write port
//   timeout_err                   : sticky watchdog flag, cleared by reset
//   dbg_state                     : current FSM state

module alg_issue_ctrl
    import lc3b_types::*;
    import alg_issue_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       ex_valid,
    input  op_x_bits   ex_op,
    input  lc3b_word   ex_opA,
    input  lc3b_word   ex_opB,
    input  lc3b_reg    ex_dest,
    output logic       stall,
    alg_issue_ctrl_if.master fu,
    output logic       wb_we,
    output lc3b_reg    wb_dest,
    output lc3b_word   wb_data,
    output logic       timeout_err,
    output alg_state_e dbg_state
);

    alg_state_e      state_q, state_d;
    lc3b_word        opa_q, opb_q, hi_q, lo_q;
    lc3b_reg         dest_q;
    logic [WD_W-1:0] wd_q;
    logic            timeout_q;
    logic            issue;
    logic            wd_expired;

    assign issue      = (state_q == IDLE) && ex_valid && (ex_op == op_mul);
    // Only meaningful in BUSY; fu_done takes priority over expiry.
    assign wd_expired = (wd_q == WD_MAX) && !fu.fu_done;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = BUSY;
            BUSY: begin
                if (fu.fu_done) begin
                    state_d = WB_HI;
                end else if (wd_expired) begin
                    state_d = IDLE;
                end
            end
            WB_HI:   state_d = WB_LO;
            WB_LO:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        stall    = (state_q != IDLE) || issue;
        fu.fu_op = op_nop;
        wb_we    = 1'b0;
        wb_dest  = '0;
        wb_data  = '0;
        case (state_q)
            BUSY: fu.fu_op = op_mul;
            WB_HI: begin
                wb_we   = 1'b1;
                wb_dest = dest_q;
                wb_data = hi_q;
            end
            WB_LO: begin
                wb_we   = 1'b1;
                wb_dest = next_reg(dest_q);
                wb_data = lo_q;
            end
            default: ;
        endcase
    end

    // Operands are presented continuously; fu_op alone qualifies them.
    assign fu.fu_opA   = opa_q;
    assign fu.fu_opB   = opb_q;
    assign timeout_err = timeout_q;
    assign dbg_state   = state_q;

    // Operand, result and watchdog registers
    always_ff @(posedge clk) begin
        if (reset) begin
            opa_q     <= '0;
            opb_q     <= '0;
            dest_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (issue) begin
                opa_q  <= ex_opA;
                opb_q  <= ex_opB;
                dest_q <= ex_dest;
                wd_q   <= '0;
            end
            if (state_q == BUSY) begin
                if (fu.fu_done) begin
                    hi_q <= fu.fu_hi;
                    lo_q <= fu.fu_lo;
                end else if (wd_expired) begin
                    timeout_q <= 1'b1;
                end else begin
                    wd_q <= wd_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alg_issue_ctrl.sv
module tb_alg_issue_ctrl;
  import lc3b_types::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       ex_valid = 1'b0;
  op_x_bits   ex_op = op_nop;
  lc3b_word   ex_opA = '0;
  lc3b_word   ex_opB = '0;
  lc3b_reg    ex_dest = '0;
  logic       stall;
  logic       wb_we;
  lc3b_reg    wb_dest;
  lc3b_word   wb_data;
  logic       timeout_err;
  alg_state_e dbg_state;
  logic [3:0] lat = 4'd2;
  logic       never_done = 1'b0;

  alg_issue_ctrl_if fu_if();

  alg_issue_ctrl dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_dest(ex_dest), .stall(stall),
    .fu(fu_if), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  alg_unit u_alg (
    .clk(clk), .reset(reset), .lat(lat), .never_done(never_done), .fu(fu_if)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [18:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Every register-file write must match the head of the expected queue.
  always @(negedge clk) begin
    if (wb_we) begin
      if (exp_q.size() == 0) begin
        check("wb_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        check("wb_write", {13'b0, wb_dest, wb_data}, {13'b0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input lc3b_word a, input lc3b_word b, input lc3b_reg d);
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = op_mul; ex_opA = a; ex_opB = b; ex_dest = d;
    #1 check("issue_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = op_nop;
  endtask

  // Counts stalled cycles after an issue, up to the first non-stalled cycle.
  task automatic wait_idle(input int limit, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (!stall) seen = 1'b1;
      else cyc++;
    end
    if (!seen) check("idle_wait", 32'(stall), 32'd0);
  endtask

  task automatic wait_wb(input int limit, input lc3b_reg d);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (wb_we && wb_dest == d) seen = 1'b1;
    end
    if (!seen) check("wb_wait", 32'(wb_we), 32'd1);
  endtask

  // ---------------- directed scenarios ----------------
  int cyc;

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_fu_op", 32'(fu_if.fu_op), 32'(op_nop));
    check("rst_wb_we", 32'(wb_we), 32'd0);
    check("rst_wb_dest", 32'(wb_dest), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    #1 reset = 1'b0;

    // 0x1234 * 0x0010 into R2/R3, unit done in 3rd BUSY cycle
    lat = 4'd2;
    exp_q.push_back({3'd2, 16'h0001});
    exp_q.push_back({3'd3, 16'h2340});
    issue(16'h1234, 16'h0010, 3'd2);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("s1_busy_state", 32'(dbg_state), 32'(BUSY));
      check("s1_busy_fu_op", 32'(fu_if.fu_op), 32'(op_mul));
      check("s1_busy_opA", 32'(fu_if.fu_opA), 32'h1234);
      check("s1_busy_opB", 32'(fu_if.fu_opB), 32'h0010);
      check("s1_busy_wb_we", 32'(wb_we), 32'd0);
      check("s1_busy_stall", 32'(stall), 32'd1);
    end
    @(negedge clk);
    check("s1_hi", {12'b0, wb_we, wb_dest, wb_data}, {12'b0, 1'b1, 3'd2, 16'h0001});
    check("s1_hi_fu_op", 32'(fu_if.fu_op), 32'(op_nop));
    @(negedge clk);
    check("s1_lo", {12'b0, wb_we, wb_dest, wb_data}, {12'b0, 1'b1, 3'd3, 16'h2340});
    @(negedge clk);
    check("s1_after_stall", 32'(stall), 32'd0);
    check("s1_after_wb_we", 32'(wb_we), 32'd0);
    check("s1_after_opA_hold", 32'(fu_if.fu_opA), 32'h1234);

    // Non-mul op with ex_valid=1, then op_mul with ex_valid=0
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = 3'd2; ex_opA = 16'h0005; ex_opB = 16'h0007; ex_dest = 3'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nonmul_stall", 32'(stall), 32'd0);
      check("nonmul_wb_we", 32'(wb_we), 32'd0);
      check("nonmul_fu_op", 32'(fu_if.fu_op), 32'(op_nop));
    end
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_op = op_mul;
    @(negedge clk);
    check("novalid_stall", 32'(stall), 32'd0);
    check("novalid_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1 ex_op = op_nop;

    // 0xFFFF * 0xFFFF into R7 with wrap to R0; single BUSY cycle (N=1)
    lat = 4'd0;
    exp_q.push_back({3'd7, 16'hFFFE});
    exp_q.push_back({3'd0, 16'h0001});
    issue(16'hFFFF, 16'hFFFF, 3'd7);
    wait_idle(40, cyc);
    check("wrap_stall_cycles", 32'(cyc), 32'd3);

    // Done arrives in the BUSY cycle where the watchdog is 15: completes
    lat = 4'd15;
    exp_q.push_back({3'd6, 16'h0001});
    exp_q.push_back({3'd7, 16'h0000});
    issue(16'h0100, 16'h0100, 3'd6);
    wait_idle(40, cyc);
    check("wd15_stall_cycles", 32'(cyc), 32'd18);
    check("wd15_timeout", 32'(timeout_err), 32'd0);

    // Unit never completes: abort after 16 BUSY cycles, no writeback
    never_done = 1'b1;
    issue(16'h0007, 16'h0007, 3'd0);
    wait_idle(40, cyc);
    check("to_stall_cycles", 32'(cyc), 32'd16);
    check("to_flag", 32'(timeout_err), 32'd1);
    check("to_state", 32'(dbg_state), 32'(IDLE));
    never_done = 1'b0;

    // Back-to-back: 3*4 into R1, then 5*6 into R4 in the first IDLE cycle
    lat = 4'd2;
    exp_q.push_back({3'd1, 16'd0});
    exp_q.push_back({3'd2, 16'd12});
    exp_q.push_back({3'd4, 16'd0});
    exp_q.push_back({3'd5, 16'd30});
    issue(16'd3, 16'd4, 3'd1);
    wait_wb(20, 3'd2);
    issue(16'd5, 16'd6, 3'd4);
    wait_idle(40, cyc);
    check("b2b_stall_cycles", 32'(cyc), 32'd5);
    check("b2b_timeout_sticky", 32'(timeout_err), 32'd1);

    // Reset during WB_HI drops the pending low-half write
    exp_q.push_back({3'd3, 16'd0});
    issue(16'd2, 16'd3, 3'd3);
    wait_wb(20, 3'd3);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_wb_we", 32'(wb_we), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_fu_op", 32'(fu_if.fu_op), 32'(op_nop));
    check("midrst_wb_dest", 32'(wb_dest), 32'd0);
    check("midrst_wb_data", 32'(wb_data), 32'd0);
    check("midrst_timeout", 32'(timeout_err), 32'd0);
    check("midrst_opA", 32'(fu_if.fu_opA), 32'd0);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));

    check("wb_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global bound in case a wait never returns.
  initial begin
    #50000;
    $display("FAIL global_timeout: sim time %0t exceeded bound", $time);
    $fatal(1, "simulation time bound exceeded");
  end

endmodule
